// File: rtl/rs_pkg.sv
// Shared types and constants for the multiply reservation station.
// Tag 0 marks an operand whose value is already present.
package rs_pkg;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam tag_t TAG_NONE = '0;

  typedef struct packed {
    logic  valid;
    data_t vj;
    data_t vk;
    tag_t  qj;
    tag_t  qk;
    tag_t  dest;
  } rs_entry_t;

  typedef enum logic [0:0] {StIdle, StBusy} fu_state_e;

  // True when a live CDB broadcast carries the tag this operand is waiting on.
  function automatic logic cdb_hit(input tag_t q, input logic cdb_valid, input tag_t cdb_tag);
    return cdb_valid && (cdb_tag != TAG_NONE) && (q == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_mul_if.sv
// Dispatch, CDB and multiply-unit signals of the multiply reservation station.
// The issue stage / environment is the master, the reservation station the slave.
interface rs_mul_if
  import rs_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = 4
);
  localparam int unsigned OCC_W = $clog2(NUM_ENTRY + 1);

  logic             dispatch_valid;
  logic             dispatch_ready;
  data_t            dispatch_Vj;
  data_t            dispatch_Vk;
  tag_t             dispatch_Qj;
  tag_t             dispatch_Qk;
  tag_t             dispatch_dest;
  logic             cdb_valid;
  tag_t             cdb_tag;
  data_t            cdb_data;
  logic [8:0]       CDB_result;
  logic             fu_en;
  data_t            fu_a;
  data_t            fu_b;
  tag_t             fu_tag;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output dispatch_valid, dispatch_Vj, dispatch_Vk, dispatch_Qj, dispatch_Qk, dispatch_dest,
    output cdb_valid, cdb_tag, cdb_data, CDB_result,
    input  dispatch_ready, fu_en, fu_a, fu_b, fu_tag, occupancy
  );

  modport slave (
    input  dispatch_valid, dispatch_Vj, dispatch_Vk, dispatch_Qj, dispatch_Qk, dispatch_dest,
    input  cdb_valid, cdb_tag, cdb_data, CDB_result,
    output dispatch_ready, fu_en, fu_a, fu_b, fu_tag, occupancy
  );

endinterface

// File: rtl/rs_select.sv
// Lowest-index priority picker over a request vector.
module rs_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Descending scan so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_mul.sv
// Reservation station feeding a single multiply unit: holds ops until both operands
// arrive on the CDB, then issues one at a time while the unit is idle.
module rs_mul
  import rs_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = 4,
  parameter int unsigned FU_INDEX  = 4
) (
  input logic    clk,
  input logic    rst,
  rs_mul_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRY);
  localparam int unsigned OCC_W = $clog2(NUM_ENTRY + 1);

  rs_entry_t [NUM_ENTRY-1:0] ent_q, ent_d;
  fu_state_e                 state_q, state_d;
  tag_t                      tag_q, tag_d;

  logic [NUM_ENTRY-1:0] free_vec, ready_vec;
  logic                 free_found, ready_found;
  logic [IDX_W-1:0]     free_idx, ready_idx;
  logic [OCC_W-1:0]     occ;
  logic                 fu_done, issue, accept;
  rs_entry_t            new_ent;

  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      free_vec[i]  = !ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && (ent_q[i].qj == TAG_NONE) && (ent_q[i].qk == TAG_NONE);
      occ          = occ + OCC_W'(ent_q[i].valid);
    end
  end

  rs_select #(
    .N     (NUM_ENTRY),
    .IDX_W (IDX_W)
  ) u_free_sel (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_select #(
    .N     (NUM_ENTRY),
    .IDX_W (IDX_W)
  ) u_ready_sel (
    .req   (ready_vec),
    .found (ready_found),
    .idx   (ready_idx)
  );

  assign fu_done = bus.CDB_result[FU_INDEX];
  assign issue   = (state_q == StIdle) && ready_found && !fu_done;
  assign accept  = bus.dispatch_valid && bus.dispatch_ready && free_found;

  assign bus.dispatch_ready = (occ != OCC_W'(NUM_ENTRY));
  assign bus.occupancy      = occ;
  assign bus.fu_en          = issue;
  assign bus.fu_a           = issue ? ent_q[ready_idx].vj : '0;
  assign bus.fu_b           = issue ? ent_q[ready_idx].vk : '0;
  assign bus.fu_tag         = issue ? ent_q[ready_idx].dest : tag_q;

  // Incoming op with same-cycle CDB bypass applied.
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.dest  = bus.dispatch_dest;
    new_ent.vj    = bus.dispatch_Vj;
    new_ent.vk    = bus.dispatch_Vk;
    new_ent.qj    = bus.dispatch_Qj;
    new_ent.qk    = bus.dispatch_Qk;
    if (cdb_hit(bus.dispatch_Qj, bus.cdb_valid, bus.cdb_tag)) begin
      new_ent.vj = bus.cdb_data;
      new_ent.qj = TAG_NONE;
    end
    if (cdb_hit(bus.dispatch_Qk, bus.cdb_valid, bus.cdb_tag)) begin
      new_ent.vk = bus.cdb_data;
      new_ent.qk = TAG_NONE;
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if (ent_q[i].valid && cdb_hit(ent_q[i].qj, bus.cdb_valid, bus.cdb_tag)) begin
        ent_d[i].vj = bus.cdb_data;
        ent_d[i].qj = TAG_NONE;
      end
      if (ent_q[i].valid && cdb_hit(ent_q[i].qk, bus.cdb_valid, bus.cdb_tag)) begin
        ent_d[i].vk = bus.cdb_data;
        ent_d[i].qk = TAG_NONE;
      end
    end
    // Issue and dispatch never touch the same slot: one is valid, the other free.
    if (issue) ent_d[ready_idx].valid = 1'b0;
    if (accept) ent_d[free_idx] = new_ent;
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StBusy;
          tag_d   = ent_q[ready_idx].dest;
        end
      end
      StBusy: begin
        if (fu_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      state_q <= StIdle;
      tag_q   <= TAG_NONE;
    end else begin
      ent_q   <= ent_d;
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_rs_mul.sv
// Bench for rs_mul: directed cycle table for the corner sequences, then random
// traffic checked against an array-based model of the reservation station.
module tb_rs_mul;
  import rs_pkg::*;

  localparam int unsigned NE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_mul_if #(.NUM_ENTRY(NE)) bus_if ();

  rs_mul #(
    .NUM_ENTRY (NE),
    .FU_INDEX  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", nm, $time, act, act, exp,
               exp);
    end
  endtask

  typedef struct {
    bit          rs, dv;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk, dest;
    bit          cv;
    logic [3:0]  ctag;
    logic [31:0] cdata;
    bit          done;
    bit          en;
    logic [31:0] a, b;
    logic [3:0]  tag;
    bit          ct, ca, rdy;
    int          occ;
  } vec_t;

  function automatic vec_t mk(input bit rs, dv, input int vj, vk, qj, qk, dest,
                              input bit cv, input int ctag, cdata, input bit done,
                              input bit en, input int a, b, tag,
                              input bit ct, ca, rdy, input int occ);
    vec_t r;
    r.rs = rs; r.dv = dv; r.vj = vj; r.vk = vk; r.qj = 4'(qj); r.qk = 4'(qk);
    r.dest = 4'(dest); r.cv = cv; r.ctag = 4'(ctag); r.cdata = cdata; r.done = done;
    r.en = en; r.a = a; r.b = b; r.tag = 4'(tag); r.ct = ct; r.ca = ca; r.rdy = rdy;
    r.occ = occ;
    return r;
  endfunction

  task automatic drive(input bit rs, dv, input logic [31:0] vj, vk, input logic [3:0] qj, qk,
                       dest, input bit cv, input logic [3:0] ctag, input logic [31:0] cdata,
                       input logic [8:0] cres);
    rst                   = rs;
    bus_if.dispatch_valid = dv;
    bus_if.dispatch_Vj    = vj;
    bus_if.dispatch_Vk    = vk;
    bus_if.dispatch_Qj    = qj;
    bus_if.dispatch_Qk    = qk;
    bus_if.dispatch_dest  = dest;
    bus_if.cdb_valid      = cv;
    bus_if.cdb_tag        = ctag;
    bus_if.cdb_data       = cdata;
    bus_if.CDB_result     = cres;
  endtask

  vec_t tbl[$];

  // Reference model state
  bit          m_v[NE];
  logic [31:0] m_vj[NE], m_vk[NE];
  logic [3:0]  m_qj[NE], m_qk[NE], m_dest[NE];
  bit          m_busy;
  logic [3:0]  m_tag;

  initial begin
    //                rs dv vj vk qj qk ds  cv ct cd dn  en a  b  tg  ct ca rd oc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 5, 0, 0, 2,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 3, 5, 2,  1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 2,  1, 0, 1, 0));
    // wait on tag 7, then wakeup
    tbl.push_back(mk(0, 1, 0, 4, 7, 0, 3,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 7, 9, 0,  0, 0, 0, 0,  0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 9, 4, 3,  1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 3,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 3,  1, 0, 1, 0));
    // dispatch-time bypass on Qk
    tbl.push_back(mk(0, 1, 6, 0, 0, 5, 4,  1, 5, 11, 0, 0, 0, 0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 6, 11, 4, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 4,  1, 0, 1, 0));
    // fill while busy, drop 5th, release
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 5,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 2, 2, 0, 0, 6,  0, 0, 0, 0,  1, 1, 1, 5,  1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 3, 3, 0, 0, 7,  0, 0, 0, 0,  0, 0, 0, 5,  1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 4, 4, 0, 0, 8,  0, 0, 0, 0,  0, 0, 0, 5,  1, 0, 1, 2));
    tbl.push_back(mk(0, 1, 5, 5, 0, 0, 9,  0, 0, 0, 0,  0, 0, 0, 5,  1, 0, 1, 3));
    tbl.push_back(mk(0, 1, 6, 6, 0, 0, 10, 0, 0, 0, 0,  0, 0, 0, 5,  1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 5,  1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 3, 3, 7,  1, 1, 0, 4));
    // done with several ready entries: no issue that cycle, lowest index next
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  0, 0, 0, 7,  1, 0, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 2, 2, 6,  1, 1, 1, 3));
    // reset while busy with three valid entries
    tbl.push_back(mk(0, 1, 7, 7, 5, 0, 11, 0, 0, 0, 0,  0, 0, 0, 6,  1, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 6,  1, 0, 1, 3));
    tbl.push_back(mk(0, 1, 8, 9, 0, 0, 12, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 8, 9, 12, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 9, 77, 0, 0, 0, 0, 12, 1, 0, 1, 0));

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h0);
    repeat (2) @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      vec_t t;
      t = tbl[r];
      @(negedge clk);
      drive(t.rs, t.dv, t.vj, t.vk, t.qj, t.qk, t.dest, t.cv, t.ctag, t.cdata,
            t.done ? 9'h010 : 9'h000);
      #1;
      chk($sformatf("row%0d fu_en", r), 32'(bus_if.fu_en), 32'(t.en));
      chk($sformatf("row%0d dispatch_ready", r), 32'(bus_if.dispatch_ready), 32'(t.rdy));
      chk($sformatf("row%0d occupancy", r), 32'(bus_if.occupancy), 32'(t.occ));
      if (t.ct) chk($sformatf("row%0d fu_tag", r), 32'(bus_if.fu_tag), 32'(t.tag));
      if (t.ca) begin
        chk($sformatf("row%0d fu_a", r), bus_if.fu_a, t.a);
        chk($sformatf("row%0d fu_b", r), bus_if.fu_b, t.b);
      end
    end

    // Random phase
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9'h0);
    for (int i = 0; i < NE; i++) m_v[i] = 0;
    m_busy = 0;
    m_tag  = 0;

    for (int c = 0; c < 3000; c++) begin
      bit          dv, cv, done, found, ffound, exp_en, exp_rdy;
      logic [31:0] vj, vk, cdata;
      logic [3:0]  qj, qk, dest, ctag;
      logic [8:0]  cres;
      int          ri, fi, occ;

      @(negedge clk);
      dv    = ($urandom_range(0, 1) == 1);
      vj    = $urandom;
      vk    = $urandom;
      qj    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      qk    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0;
      dest  = 4'($urandom_range(1, 15));
      cv    = ($urandom_range(0, 2) == 0);
      ctag  = 4'($urandom_range(0, 8));
      cdata = $urandom;
      done  = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cres  = 9'($urandom);
      cres[4] = done;
      drive(0, dv, vj, vk, qj, qk, dest, cv, ctag, cdata, cres);
      #1;

      found = 0; ri = 0; ffound = 0; fi = 0; occ = 0;
      for (int i = 0; i < NE; i++) begin
        if (m_v[i]) occ++;
        if (!found && m_v[i] && m_qj[i] == 0 && m_qk[i] == 0) begin found = 1; ri = i; end
        if (!ffound && !m_v[i]) begin ffound = 1; fi = i; end
      end
      exp_rdy = (occ < NE);
      exp_en  = !m_busy && !done && found;

      chk("rand fu_en", 32'(bus_if.fu_en), 32'(exp_en));
      chk("rand dispatch_ready", 32'(bus_if.dispatch_ready), 32'(exp_rdy));
      chk("rand occupancy", 32'(bus_if.occupancy), 32'(occ));
      if (exp_en) begin
        chk("rand fu_a", bus_if.fu_a, m_vj[ri]);
        chk("rand fu_b", bus_if.fu_b, m_vk[ri]);
        chk("rand fu_tag", 32'(bus_if.fu_tag), 32'(m_dest[ri]));
      end else if (m_busy) begin
        chk("rand fu_tag busy", 32'(bus_if.fu_tag), 32'(m_tag));
      end

      for (int i = 0; i < NE; i++) begin
        if (m_v[i] && cv && ctag != 0) begin
          if (m_qj[i] == ctag) begin m_vj[i] = cdata; m_qj[i] = 0; end
          if (m_qk[i] == ctag) begin m_vk[i] = cdata; m_qk[i] = 0; end
        end
      end
      if (exp_en) begin
        m_v[ri] = 0;
        m_busy  = 1;
        m_tag   = m_dest[ri];
      end else if (m_busy && done) begin
        m_busy = 0;
      end
      if (dv && exp_rdy) begin
        m_v[fi]    = 1;
        m_dest[fi] = dest;
        m_vj[fi]   = vj;
        m_vk[fi]   = vk;
        m_qj[fi]   = qj;
        m_qk[fi]   = qk;
        if (cv && ctag != 0 && qj == ctag) begin m_vj[fi] = cdata; m_qj[fi] = 0; end
        if (cv && ctag != 0 && qk == ctag) begin m_vk[fi] = cdata; m_qk[fi] = 0; end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
